// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a FIFO read port into a valid/ready stream; FIFO_RD_STREAM_LAST_EN adds m_last framing
module fifo_rd_stream #(
  parameter int FIFO_WIDTH = 32,
  parameter int PKT_LEN    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last
);
  logic [1:0]            occ;
  logic                  inflight;
  logic [FIFO_WIDTH-1:0] head, skid;
  logic                  pop, head_ld_fifo, head_ld_skid, skid_ld;
  logic [2:0]            occ_nxt;
  always_comb begin
    pop          = m_valid && m_ready;
    fifo_rd_en   = rst_n && !fifo_empty && (({1'b0, occ} + {2'b0, inflight} < 3'd2) || pop);
    occ_nxt      = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    head_ld_fifo = inflight && (occ == 2'd0 || (pop && occ == 2'd1));
    head_ld_skid = pop && occ == 2'd2;
    skid_ld      = inflight && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= '0;
      inflight <= 1'b0;
      head     <= '0;
      skid     <= '0;
    end else begin
      assert (occ_nxt <= 3'd2);
      assert (PKT_LEN >= 1 && PKT_LEN <= 65535);
      occ      <= occ_nxt[1:0];
      inflight <= fifo_rd_en;
      if (head_ld_fifo) head <= fifo_rd_data;
      else if (head_ld_skid) head <= skid;
      if (skid_ld) skid <= fifo_rd_data;
    end
  end
  assign m_valid = occ != 2'd0;
  assign m_data  = head;
`ifdef FIFO_RD_STREAM_LAST_EN
  localparam int BW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  logic [BW-1:0] beat_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_cnt <= '0;
    else if (pop) beat_cnt <= beat_cnt == BW'(PKT_LEN - 1) ? '0 : beat_cnt + BW'(1);
  end
  assign m_last = m_valid && beat_cnt == BW'(PKT_LEN - 1);
`else
  assign m_last = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed and random checks of fifo_rd_stream against a queue-based FIFO/stream model
module tb_fifo_rd_stream;
  localparam int W = 32;
  localparam int P = 4;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fifo_empty, fifo_rd_en, m_valid, m_ready = 1'b0, m_last;
  logic [W-1:0] fifo_rd_data = '0, m_data;
  logic [W-1:0] mem [1024];
  int           wr_ptr = 0, rd_ptr = 0;
  logic [W-1:0] exp_q [$];
  int           errors = 0, checks = 0;
  int           reads = 0, pops = 0, beats = 0, rd_pulses = 0;
  logic [31:0]  last_mask = '0;
  logic         stall = 1'b0, exp_last;
  logic [W-1:0] stall_data = '0;

  fifo_rd_stream #(.FIFO_WIDTH(W), .PKT_LEN(P)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO with one-cycle read latency, flushed by the shared reset
  assign fifo_empty = rd_ptr == wr_ptr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr % 1024];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [W-1:0] v);
    mem[wr_ptr % 1024] = v;
    wr_ptr++;
    exp_q.push_back(v);
  endtask

  task automatic wait_valid(input int lim);
    int n = 0;
    while (!m_valid && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", m_valid, 1);
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Stream monitor: order, stability under stall, occupancy bound, framing
  always @(negedge clk) begin
    if (!rst_n) begin
      reads = 0; pops = 0; beats = 0; rd_pulses = 0; stall = 1'b0; last_mask = '0;
    end else begin
`ifdef FIFO_RD_STREAM_LAST_EN
      exp_last = m_valid && (beats % P == P - 1);
`else
      exp_last = 1'b0;
`endif
      chk("rd_en_while_empty", fifo_rd_en && fifo_empty, 0);
      chk("held_le_2", (reads - pops) <= 2, 1);
      chk("m_last", m_last, exp_last);
      if (stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, stall_data);
      end
      if (m_valid && m_ready) begin
        chk("pop_has_word", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("order", m_data, exp_q.pop_front());
        if (beats < 32) last_mask[beats] = m_last;
        beats++;
        pops++;
      end
      if (fifo_rd_en) begin
        reads++;
        rd_pulses++;
      end
      stall      = m_valid && !m_ready;
      stall_data = m_data;
    end
  end

  initial begin
    int base, written, cyc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // single word: one read, valid two cycles later for exactly one cycle
    m_ready = 1'b1;
    base = rd_pulses;
    push(32'hA5A5_0001);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_rd_en", fifo_rd_en, i == 0);
      chk("t1_valid", m_valid, i == 2);
      if (i == 2) chk("t1_data", m_data, 32'hA5A5_0001);
    end
    @(posedge clk); #1;
    chk("t1_rd_pulses", rd_pulses - base, 1);
    // 16 preloaded words stream with no gaps
    for (int i = 0; i < 16; i++) push(W'(i));
    wait_valid(10);
    for (int i = 0; i < 16; i++) begin
      chk("t2_no_gap", m_valid, 1);
      @(negedge clk);
    end
    chk("t2_end", m_valid, 0);
    @(posedge clk); #1;
    // back-pressure: two reads only, head holds word 0, then back-to-back on release
    m_ready = 1'b0;
    base = rd_pulses;
    for (int i = 0; i < 16; i++) push(W'(i));
    repeat (10) begin
      @(posedge clk); #1;
      if (m_valid) chk("t3_hold_data", m_data, 0);
    end
    chk("t3_rd_pulses", rd_pulses - base, 2);
    chk("t3_held", reads - pops, 2);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("t3_no_gap", m_valid, 1);
    end
    @(negedge clk);
    chk("t3_end", m_valid, 0);
    @(posedge clk); #1;
    // random back-pressure and bursty writes
    written = 0;
    cyc = 0;
    while ((written < 200 || exp_q.size() != 0) && cyc < 4000) begin
      @(posedge clk); #1;
      m_ready = 1'($urandom_range(0, 1));
      if (written < 200 && $urandom_range(0, 3) != 0) begin
        push($urandom);
        written++;
      end
      cyc++;
    end
    chk("t4_drain", exp_q.size(), 0);
    // reset with a full buffer discards everything
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h5555_0000 + W'(i));
    repeat (5) @(posedge clk);
    #1;
    chk("t5_held", reads - pops, 2);
    m_ready = 1'b1;
    #1;
    chk("t5_rd_en_pre", fifo_rd_en, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_valid", m_valid, 0);
    chk("t5_rd_en", fifo_rd_en, 0);
    chk("t5_last", m_last, 0);
    chk("t5_data", m_data, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_post_valid", m_valid, 0);
    for (int i = 0; i < 3; i++) push(32'hBEEF_0001 + W'(i));
    wait_valid(10);
    chk("t5_first", m_data, 32'hBEEF_0001);
    wait_drain(40);
    // framing over 12 beats
    @(posedge clk); #1;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) push(32'h0C00_0000 + W'(i));
    wait_drain(40);
    chk("t6_beats", beats, 12);
`ifdef FIFO_RD_STREAM_LAST_EN
    chk("t6_last_mask", last_mask, 32'h0000_0888);
`else
    chk("t6_last_mask", last_mask, 32'h0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
